// File: rtl/parking_gate_ctrl.sv
// Single-gate parking controller: password check with evaluation delay, occupancy count
// with capacity limit, optional wrong-attempt lockout (enabled by defining PARK_LOCKOUT_EN).
//
// state          | meaning
// IDLE           | gate closed, waiting for a car at the entrance
// WAIT_PASSWORD  | car present, letting the keypad settle before comparing
// WRONG_PASS     | last evaluation rejected, waiting for a changed entry
// RIGHT_PASS     | gate open, waiting for the car to pass the exit sensor
// STOP           | tailgater detected behind an admitted car, re-evaluating
// LOCKED         | too many rejections, sensors ignored for a fixed time
module parking_gate_ctrl #(
   parameter int PW_WIDTH    = 2,
   parameter int PASS_1      = 1,
   parameter int PASS_2      = 2,
   parameter int CAPACITY    = 8,
   parameter int WAIT_CYCLES = 3,
   parameter int MAX_TRIES   = 3,
   parameter int LOCK_CYCLES = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          sensor_entrance,
   input  logic                          sensor_exit,
   input  logic                          car_leave,
   input  logic [PW_WIDTH-1:0]           password_1,
   input  logic [PW_WIDTH-1:0]           password_2,
   output logic                          GREEN_LED,
   output logic                          RED_LED,
   output logic [6:0]                    HEX_1,
   output logic [6:0]                    HEX_2,
   output logic [$clog2(CAPACITY+1)-1:0] occupancy,
   output logic                          full,
   output logic                          locked
);

   localparam int OW = $clog2(CAPACITY + 1);
`ifdef PARK_LOCKOUT_EN
   localparam int CNT_MAX = (WAIT_CYCLES > LOCK_CYCLES) ? WAIT_CYCLES : LOCK_CYCLES;
   localparam int TW      = $clog2(MAX_TRIES + 1);
`else
   localparam int CNT_MAX = WAIT_CYCLES;
`endif
   localparam int CW = $clog2(CNT_MAX + 1);

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_N     = 7'h2B;
   localparam logic [6:0] SEG_G     = 7'h42;
   localparam logic [6:0] SEG_O     = 7'h40;
   localparam logic [6:0] SEG_S     = 7'h12;
   localparam logic [6:0] SEG_P     = 7'h0C;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_U     = 7'h41;
   localparam logic [6:0] SEG_L     = 7'h47;
   localparam logic [6:0] SEG_C     = 7'h46;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_PASSWORD,
      S_WRONG_PASS,
      S_RIGHT_PASS,
      S_STOP
`ifdef PARK_LOCKOUT_EN
      , S_LOCKED
`endif
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [PW_WIDTH-1:0] rej1_q, rej1_d;
   logic [PW_WIDTH-1:0] rej2_q, rej2_d;
   logic [OW-1:0]       occ_q, occ_d;
   logic                rej_idle_q, rej_idle_d;
   logic                car_in;
   logic                dec_req;
   logic                pw_match;
`ifdef PARK_LOCKOUT_EN
   logic [TW-1:0]       tries_q, tries_d;
`else
   logic                unused_cfg;
   assign unused_cfg = (MAX_TRIES == LOCK_CYCLES);
`endif

   assign pw_match = (password_1 == PW_WIDTH'(PASS_1)) && (password_2 == PW_WIDTH'(PASS_2));
   assign full     = (occ_q == OW'(CAPACITY));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rej1_d  = rej1_q;
      rej2_d  = rej2_q;
      car_in  = 1'b0;
`ifdef PARK_LOCKOUT_EN
      tries_d = tries_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (sensor_entrance && !full) begin
               state_d = S_WAIT_PASSWORD;
               cnt_d   = '0;
            end
         end
         S_WAIT_PASSWORD, S_STOP: begin
            cnt_d = cnt_q + 1'b1;
            if (!sensor_entrance) begin
               state_d = S_IDLE;
               cnt_d   = '0;
`ifdef PARK_LOCKOUT_EN
               tries_d = '0;
`endif
            end else if (cnt_q == CW'(WAIT_CYCLES - 1)) begin
               cnt_d = '0;
               if (pw_match) begin
                  state_d = S_RIGHT_PASS;
`ifdef PARK_LOCKOUT_EN
                  tries_d = '0;
`endif
               end else begin
                  rej1_d  = password_1;
                  rej2_d  = password_2;
`ifdef PARK_LOCKOUT_EN
                  tries_d = tries_q + 1'b1;
                  state_d = (tries_q + 1'b1 == TW'(MAX_TRIES)) ? S_LOCKED : S_WRONG_PASS;
`else
                  state_d = S_WRONG_PASS;
`endif
               end
            end
         end
         S_WRONG_PASS: begin
            if (!sensor_entrance) begin
               state_d = S_IDLE;
`ifdef PARK_LOCKOUT_EN
               tries_d = '0;
`endif
            end else if (password_1 != rej1_q || password_2 != rej2_q) begin
               state_d = S_WAIT_PASSWORD;
               cnt_d   = '0;
            end
         end
         S_RIGHT_PASS: begin
            if (sensor_exit) begin
               car_in  = 1'b1;
               cnt_d   = '0;
               state_d = sensor_entrance ? S_STOP : S_IDLE;
            end
         end
`ifdef PARK_LOCKOUT_EN
         S_LOCKED: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(LOCK_CYCLES - 1)) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               tries_d = '0;
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // A car arriving and one leaving in the same cycle cancel; a leave at zero is no event.
   assign dec_req = car_leave && (occ_q != '0);

   always_comb begin
      occ_d = occ_q;
      if (car_in && !dec_req) begin
         if (occ_q != OW'(CAPACITY)) occ_d = occ_q + 1'b1;
      end else if (dec_req && !car_in) begin
         occ_d = occ_q - 1'b1;
      end
   end

   // Registered so the full-lot rejection LED stays a Moore output.
   assign rej_idle_d = (state_d == S_IDLE) && sensor_entrance && (occ_d == OW'(CAPACITY));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         rej1_q     <= '0;
         rej2_q     <= '0;
         occ_q      <= '0;
         rej_idle_q <= 1'b0;
`ifdef PARK_LOCKOUT_EN
         tries_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rej1_q     <= rej1_d;
         rej2_q     <= rej2_d;
         occ_q      <= occ_d;
         rej_idle_q <= rej_idle_d;
`ifdef PARK_LOCKOUT_EN
         tries_q    <= tries_d;
`endif
      end
   end

   always_comb begin
      GREEN_LED = 1'b0;
      RED_LED   = 1'b0;
      HEX_1     = SEG_BLANK;
      HEX_2     = SEG_BLANK;
      case (state_q)
         S_IDLE: begin
            RED_LED = rej_idle_q;
            if (full) begin
               HEX_1 = SEG_F;
               HEX_2 = SEG_U;
            end
         end
         S_WAIT_PASSWORD: begin
            HEX_1 = SEG_E;
            HEX_2 = SEG_N;
         end
         S_WRONG_PASS: begin
            RED_LED = 1'b1;
            HEX_1   = SEG_E;
            HEX_2   = SEG_E;
         end
         S_RIGHT_PASS: begin
            GREEN_LED = 1'b1;
            HEX_1     = SEG_G;
            HEX_2     = SEG_O;
         end
         S_STOP: begin
            RED_LED = 1'b1;
            HEX_1   = SEG_S;
            HEX_2   = SEG_P;
         end
`ifdef PARK_LOCKOUT_EN
         S_LOCKED: begin
            RED_LED = 1'b1;
            HEX_1   = SEG_L;
            HEX_2   = SEG_C;
         end
`endif
         default: begin
            HEX_1 = SEG_BLANK;
            HEX_2 = SEG_BLANK;
         end
      endcase
   end

   assign occupancy = occ_q;
`ifdef PARK_LOCKOUT_EN
   assign locked = (state_q == S_LOCKED);
`else
   assign locked = 1'b0;
`endif

endmodule
